mem_access_ctrl: RTL and testbench

- Owns the shared cartridge SRAM and arbitrates between the SNES bus and the MCU.
- The MCU loads a 21-bit access address serially, then issues read or write requests with optional address auto-increment.
- SNES cycles always have priority. The block drives all SRAM control pins and sits between the MCU interface pins and the SRAM.

---
 rtl/mem_access_ctrl_pkg.sv | 16 +
 rtl/mem_access_ctrl_sync2.sv | 26 ++
 rtl/mem_access_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_ctrl_pkg.sv
// Shared constants for the cartridge SRAM access controller: FSM encoding,
// default bus widths and synchroniser depth.
package mem_access_ctrl_pkg;

    localparam int AWIDTH_DEF = 21;
    localparam int DWIDTH_DEF = 8;
    localparam int SYNC_DEPTH = 2;

    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_SNES       = 3'd1;
    localparam logic [2:0] ST_MCU_SETUP  = 3'd2;
    localparam logic [2:0] ST_MCU_ACCESS = 3'd3;
    localparam logic [2:0] ST_MCU_DONE   = 3'd4;
    localparam logic [2:0] ST_ABORT      = 3'd5;

endpackage

// File: rtl/mem_access_ctrl_sync2.sv
// Multi-flop synchroniser for a single asynchronous MCU pin; the reset value
// is chosen per pin so that idle-high signals do not glitch out of reset.
module mem_access_ctrl_sync2
    import mem_access_ctrl_pkg::*;
#(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic [SYNC_DEPTH-1:0] ff_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ff_q <= {SYNC_DEPTH{RST_VAL}};
        end else begin
            ff_q <= {ff_q[SYNC_DEPTH-2:0], d_i};
        end
    end

    assign q_o = ff_q[SYNC_DEPTH-1];

endmodule

// File: rtl/mem_access_ctrl.sv
// Arbitrates the shared cartridge SRAM between the SNES bus (always first)
// and an MCU that loads an address serially and issues single-byte accesses.
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int AWIDTH     = AWIDTH_DEF,
    parameter int DWIDTH     = DWIDTH_DEF,
    parameter int ACC_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mcu_sclk,
    input  logic              mcu_sdi,
    input  logic              mcu_en_n,
    input  logic              mcu_req,
    input  logic              mcu_we,
    input  logic              mcu_inc_n,
    input  logic [DWIDTH-1:0] mcu_wdata,
    output logic [DWIDTH-1:0] mcu_rdata,
    output logic              mcu_busy,
    input  logic              snes_cs_n,
    input  logic              snes_rd_n,
    input  logic              snes_wr_n,
    input  logic [AWIDTH-1:0] snes_addr,
    output logic [AWIDTH-1:0] sram_addr,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n,
    output logic [DWIDTH-1:0] sram_dout,
    output logic              sram_dout_en,
    input  logic [DWIDTH-1:0] sram_din,
    output logic [7:0]        debug
);

    localparam int CW = (ACC_CYCLES > 1) ? $clog2(ACC_CYCLES) : 1;

    logic sclk_s, sdi_s, en_n_s, req_s, inc_n_s;

    mem_access_ctrl_sync2 #(.RST_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .rst(rst), .d_i(mcu_sclk), .q_o(sclk_s));
    mem_access_ctrl_sync2 #(.RST_VAL(1'b0)) u_sync_sdi (
        .clk(clk), .rst(rst), .d_i(mcu_sdi), .q_o(sdi_s));
    mem_access_ctrl_sync2 #(.RST_VAL(1'b1)) u_sync_en_n (
        .clk(clk), .rst(rst), .d_i(mcu_en_n), .q_o(en_n_s));
    mem_access_ctrl_sync2 #(.RST_VAL(1'b0)) u_sync_req (
        .clk(clk), .rst(rst), .d_i(mcu_req), .q_o(req_s));
    mem_access_ctrl_sync2 #(.RST_VAL(1'b1)) u_sync_inc_n (
        .clk(clk), .rst(rst), .d_i(mcu_inc_n), .q_o(inc_n_s));

    logic [2:0]        state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [AWIDTH-1:0] addr_q, addr_d;
    logic [DWIDTH-1:0] rdata_q, rdata_d;
    logic [DWIDTH-1:0] wdata_q, wdata_d;
    logic              busy_q, busy_d;
    logic              pending_q, pending_d;
    logic              we_q, we_d;
    logic              sclk_prev_q, req_prev_q;

    logic shift_fire, req_fire, snes_active, acc_last;

    // Request handshake: a synchronised rising edge of mcu_req is accepted only
    // while busy is low; busy then stays high until the access completes.
    assign shift_fire  = sclk_s & ~sclk_prev_q & ~en_n_s & ~busy_q;
    assign req_fire    = req_s & ~req_prev_q & ~busy_q;
    assign snes_active = ~snes_cs_n & (~snes_rd_n | ~snes_wr_n);
    assign acc_last    = (cnt_q == CW'(ACC_CYCLES - 1));

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        rdata_d   = rdata_q;
        wdata_d   = wdata_q;
        busy_d    = busy_q;
        pending_d = pending_q;
        we_d      = we_q;

        if (shift_fire) begin
            addr_d = {addr_q[AWIDTH-2:0], sdi_s};
        end
        if (req_fire) begin
            we_d      = mcu_we;
            wdata_d   = mcu_wdata;
            pending_d = 1'b1;
            busy_d    = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                // A request latched this very cycle may start at once, but the
                // SNES still wins a same-cycle tie.
                if (snes_active) begin
                    state_d = ST_SNES;
                end else if (pending_q || req_fire) begin
                    state_d = ST_MCU_SETUP;
                end
            end
            ST_SNES: begin
                if (!snes_active) begin
                    state_d = ST_IDLE;
                end
            end
            ST_MCU_SETUP: begin
                cnt_d = '0;
                if (snes_active) begin
                    state_d = ST_ABORT;
                end else begin
                    state_d = ST_MCU_ACCESS;
                end
            end
            ST_MCU_ACCESS: begin
                if (snes_active) begin
                    state_d = ST_ABORT;
                end else if (acc_last) begin
                    if (!we_q) begin
                        rdata_d = sram_din;
                    end
                    state_d = ST_MCU_DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_MCU_DONE: begin
                pending_d = 1'b0;
                busy_d    = 1'b0;
                if (!inc_n_s) begin
                    addr_d = addr_q + AWIDTH'(1);
                end
                state_d = ST_IDLE;
            end
            ST_ABORT: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            addr_q      <= '0;
            rdata_q     <= '0;
            wdata_q     <= '0;
            busy_q      <= 1'b0;
            pending_q   <= 1'b0;
            we_q        <= 1'b0;
            sclk_prev_q <= 1'b0;
            req_prev_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            rdata_q     <= rdata_d;
            wdata_q     <= wdata_d;
            busy_q      <= busy_d;
            pending_q   <= pending_d;
            we_q        <= we_d;
            sclk_prev_q <= sclk_s;
            req_prev_q  <= req_s;
        end
    end

    // SRAM pins decode straight from the state register so reset releases
    // every strobe without waiting for a clock.
    always_comb begin
        sram_addr    = addr_q;
        sram_ce_n    = 1'b1;
        sram_oe_n    = 1'b1;
        sram_we_n    = 1'b1;
        sram_dout_en = 1'b0;
        case (state_q)
            ST_SNES: begin
                sram_addr = snes_addr;
                sram_ce_n = 1'b0;
                sram_oe_n = snes_rd_n;
                sram_we_n = snes_wr_n;
            end
            ST_MCU_SETUP: begin
                sram_ce_n    = 1'b0;
                sram_dout_en = we_q;
            end
            ST_MCU_ACCESS: begin
                sram_ce_n    = 1'b0;
                sram_oe_n    = we_q;
                sram_we_n    = ~we_q;
                sram_dout_en = we_q;
            end
            ST_MCU_DONE: begin
                sram_ce_n    = 1'b0;
                sram_dout_en = we_q;
            end
            default: begin
                sram_addr = addr_q;
            end
        endcase
    end

    assign sram_dout = wdata_q;
    assign mcu_rdata = rdata_q;
    assign mcu_busy  = busy_q;
    assign debug     = {state_q, busy_q, pending_q, addr_q[2:0]};

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: address load, MCU write/read, SNES
// preemption, simultaneous start and reset during an access.
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mcu_sclk = 1'b0;
    logic        mcu_sdi = 1'b0;
    logic        mcu_en_n = 1'b1;
    logic        mcu_req = 1'b0;
    logic        mcu_we = 1'b0;
    logic        mcu_inc_n = 1'b1;
    logic [7:0]  mcu_wdata = 8'h00;
    logic [7:0]  mcu_rdata;
    logic        mcu_busy;
    logic        snes_cs_n = 1'b1;
    logic        snes_rd_n = 1'b1;
    logic        snes_wr_n = 1'b1;
    logic [20:0] snes_addr = 21'h0;
    logic [20:0] sram_addr;
    logic        sram_ce_n, sram_oe_n, sram_we_n, sram_dout_en;
    logic [7:0]  sram_dout;
    logic [7:0]  sram_din = 8'h00;
    logic [7:0]  debug;

    int n_vec = 0;
    int n_err = 0;

    mem_access_ctrl dut (
        .clk(clk), .rst(rst),
        .mcu_sclk(mcu_sclk), .mcu_sdi(mcu_sdi), .mcu_en_n(mcu_en_n),
        .mcu_req(mcu_req), .mcu_we(mcu_we), .mcu_inc_n(mcu_inc_n),
        .mcu_wdata(mcu_wdata), .mcu_rdata(mcu_rdata), .mcu_busy(mcu_busy),
        .snes_cs_n(snes_cs_n), .snes_rd_n(snes_rd_n), .snes_wr_n(snes_wr_n),
        .snes_addr(snes_addr), .sram_addr(sram_addr), .sram_ce_n(sram_ce_n),
        .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n), .sram_dout(sram_dout),
        .sram_dout_en(sram_dout_en), .sram_din(sram_din), .debug(debug)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic shift_addr(input logic [20:0] a);
        mcu_en_n = 1'b0;
        for (int i = 20; i >= 0; i--) begin
            mcu_sdi  = a[i];
            mcu_sclk = 1'b0;
            tick(4);
            mcu_sclk = 1'b1;
            tick(4);
        end
        mcu_sclk = 1'b0;
        mcu_en_n = 1'b1;
        tick(4);
    endtask

    task automatic drop_req;
        mcu_req = 1'b0;
        tick(4);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick(2);
        n_vec++; if (mcu_busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", mcu_busy); end
        n_vec++; if (mcu_rdata !== 8'h00) begin n_err++; $display("FAIL rst_rdata: got %h want 00", mcu_rdata); end
        n_vec++; if ({sram_ce_n, sram_oe_n, sram_we_n, sram_dout_en} !== 4'b1110) begin
            n_err++; $display("FAIL rst_strobes: got %b want 1110", {sram_ce_n, sram_oe_n, sram_we_n, sram_dout_en}); end
        n_vec++; if (debug !== 8'h00) begin n_err++; $display("FAIL rst_debug: got %h want 00", debug); end
        rst = 1'b0;
        tick(2);
    endtask

    task automatic test_addr_load;
        shift_addr(21'h12345);
        n_vec++; if (debug[2:0] !== 3'b101) begin n_err++; $display("FAIL load_dbg: got %b want 101", debug[2:0]); end
        mcu_we = 1'b0; mcu_inc_n = 1'b1; sram_din = 8'h11;
        mcu_req = 1'b1;
        tick(4);
        n_vec++; if (sram_addr !== 21'h12345) begin n_err++; $display("FAIL load_addr: got %h want 12345", sram_addr); end
        tick(4);
        drop_req();
    endtask

    task automatic test_write;
        shift_addr(21'h00010);
        mcu_we = 1'b1; mcu_wdata = 8'hA5; mcu_inc_n = 1'b0;
        mcu_req = 1'b1;
        tick(3);
        n_vec++; if (debug[7:5] !== 3'd2 || mcu_busy !== 1'b1) begin
            n_err++; $display("FAIL wr_setup: got st=%0d busy=%b want st=2 busy=1", debug[7:5], mcu_busy); end
        n_vec++; if (sram_dout_en !== 1'b1 || sram_ce_n !== 1'b0 || sram_we_n !== 1'b1) begin
            n_err++; $display("FAIL wr_setup_pins: got en=%b ce=%b we=%b want 1 0 1", sram_dout_en, sram_ce_n, sram_we_n); end
        tick(1);
        n_vec++; if (sram_we_n !== 1'b0 || sram_oe_n !== 1'b1 || sram_addr !== 21'h10 || sram_dout !== 8'hA5) begin
            n_err++; $display("FAIL wr_acc1: got we=%b oe=%b a=%h d=%h want 0 1 10 a5", sram_we_n, sram_oe_n, sram_addr, sram_dout); end
        tick(1);
        n_vec++; if (sram_we_n !== 1'b0) begin n_err++; $display("FAIL wr_acc2: got we=%b want 0", sram_we_n); end
        tick(1);
        n_vec++; if (sram_we_n !== 1'b1 || sram_dout_en !== 1'b1 || mcu_busy !== 1'b1) begin
            n_err++; $display("FAIL wr_done: got we=%b en=%b busy=%b want 1 1 1", sram_we_n, sram_dout_en, mcu_busy); end
        tick(1);
        n_vec++; if (mcu_busy !== 1'b0 || sram_addr !== 21'h11 || sram_ce_n !== 1'b1) begin
            n_err++; $display("FAIL wr_end: got busy=%b a=%h ce=%b want 0 11 1", mcu_busy, sram_addr, sram_ce_n); end
        drop_req();
    endtask

    task automatic test_read_wrap;
        shift_addr(21'h1FFFFF);
        sram_din = 8'h3C; mcu_we = 1'b0; mcu_inc_n = 1'b0;
        mcu_req = 1'b1;
        tick(3);
        n_vec++; if (sram_dout_en !== 1'b0 || sram_addr !== 21'h1FFFFF) begin
            n_err++; $display("FAIL rd_setup: got en=%b a=%h want 0 1fffff", sram_dout_en, sram_addr); end
        tick(1);
        n_vec++; if (sram_oe_n !== 1'b0 || sram_we_n !== 1'b1) begin
            n_err++; $display("FAIL rd_acc: got oe=%b we=%b want 0 1", sram_oe_n, sram_we_n); end
        tick(2);
        n_vec++; if (mcu_rdata !== 8'h3C) begin n_err++; $display("FAIL rd_data: got %h want 3c", mcu_rdata); end
        tick(1);
        n_vec++; if (sram_addr !== 21'h0 || mcu_busy !== 1'b0) begin
            n_err++; $display("FAIL rd_wrap: got a=%h busy=%b want 0 0", sram_addr, mcu_busy); end
        sram_din = 8'hEE;
        tick(2);
        n_vec++; if (mcu_rdata !== 8'h3C) begin n_err++; $display("FAIL rd_hold: got %h want 3c", mcu_rdata); end
        drop_req();
    endtask

    task automatic test_preempt;
        shift_addr(21'h00100);
        mcu_we = 1'b1; mcu_wdata = 8'h5A; mcu_inc_n = 1'b0;
        mcu_req = 1'b1;
        tick(4);
        snes_cs_n = 1'b0; snes_rd_n = 1'b0; snes_addr = 21'h0ABCD;
        tick(1);
        n_vec++; if (debug[7:5] !== 3'd5 || debug[3] !== 1'b1) begin
            n_err++; $display("FAIL pre_abort: got st=%0d pend=%b want 5 1", debug[7:5], debug[3]); end
        n_vec++; if ({sram_ce_n, sram_oe_n, sram_we_n, sram_dout_en} !== 4'b1110) begin
            n_err++; $display("FAIL pre_abort_pins: got %b want 1110", {sram_ce_n, sram_oe_n, sram_we_n, sram_dout_en}); end
        tick(2);
        n_vec++; if (sram_addr !== 21'h0ABCD || sram_oe_n !== 1'b0 || sram_ce_n !== 1'b0 || mcu_busy !== 1'b1) begin
            n_err++; $display("FAIL pre_snes: got a=%h oe=%b ce=%b busy=%b want 0abcd 0 0 1", sram_addr, sram_oe_n, sram_ce_n, mcu_busy); end
        snes_cs_n = 1'b1; snes_rd_n = 1'b1;
        tick(3);
        n_vec++; if (sram_we_n !== 1'b0 || sram_addr !== 21'h100) begin
            n_err++; $display("FAIL pre_rerun: got we=%b a=%h want 0 100", sram_we_n, sram_addr); end
        tick(3);
        n_vec++; if (mcu_busy !== 1'b0 || sram_addr !== 21'h101) begin
            n_err++; $display("FAIL pre_end: got busy=%b a=%h want 0 101", mcu_busy, sram_addr); end
        drop_req();
    endtask

    task automatic test_simultaneous;
        shift_addr(21'h00200);
        mcu_we = 1'b0; mcu_inc_n = 1'b1; sram_din = 8'h77;
        mcu_req = 1'b1;
        tick(2);
        snes_cs_n = 1'b0; snes_wr_n = 1'b0; snes_addr = 21'h01234;
        tick(1);
        n_vec++; if (debug[7:5] !== 3'd1 || mcu_busy !== 1'b1 || debug[3] !== 1'b1) begin
            n_err++; $display("FAIL sim_snes: got st=%0d busy=%b pend=%b want 1 1 1", debug[7:5], mcu_busy, debug[3]); end
        n_vec++; if (sram_we_n !== 1'b0 || sram_dout_en !== 1'b0 || sram_addr !== 21'h01234) begin
            n_err++; $display("FAIL sim_pass: got we=%b en=%b a=%h want 0 0 01234", sram_we_n, sram_dout_en, sram_addr); end
        tick(1);
        snes_cs_n = 1'b1; snes_wr_n = 1'b1;
        tick(2);
        n_vec++; if (debug[7:5] !== 3'd2 || mcu_busy !== 1'b1) begin
            n_err++; $display("FAIL sim_setup: got st=%0d busy=%b want 2 1", debug[7:5], mcu_busy); end
        tick(3);
        n_vec++; if (mcu_busy !== 1'b1 || mcu_rdata !== 8'h77) begin
            n_err++; $display("FAIL sim_done: got busy=%b rd=%h want 1 77", mcu_busy, mcu_rdata); end
        tick(1);
        n_vec++; if (mcu_busy !== 1'b0 || sram_addr !== 21'h200) begin
            n_err++; $display("FAIL sim_end: got busy=%b a=%h want 0 200", mcu_busy, sram_addr); end
        drop_req();
    endtask

    task automatic test_reset_mid;
        shift_addr(21'h00333);
        mcu_we = 1'b1; mcu_wdata = 8'hC3; mcu_inc_n = 1'b0;
        mcu_req = 1'b1;
        tick(4);
        n_vec++; if (sram_we_n !== 1'b0) begin n_err++; $display("FAIL rm_pre: got we=%b want 0", sram_we_n); end
        rst = 1'b1;
        #1;
        n_vec++; if ({sram_ce_n, sram_oe_n, sram_we_n, sram_dout_en} !== 4'b1110) begin
            n_err++; $display("FAIL rm_pins: got %b want 1110", {sram_ce_n, sram_oe_n, sram_we_n, sram_dout_en}); end
        n_vec++; if (mcu_busy !== 1'b0 || sram_addr !== 21'h0 || mcu_rdata !== 8'h00) begin
            n_err++; $display("FAIL rm_state: got busy=%b a=%h rd=%h want 0 0 00", mcu_busy, sram_addr, mcu_rdata); end
        mcu_req = 1'b0;
        tick(2);
        rst = 1'b0;
        tick(6);
        n_vec++; if (mcu_busy !== 1'b0 || debug[7:5] !== 3'd0) begin
            n_err++; $display("FAIL rm_after: got busy=%b st=%0d want 0 0", mcu_busy, debug[7:5]); end
    endtask

    initial begin
        test_reset();
        test_addr_load();
        test_write();
        test_read_wrap();
        test_preempt();
        test_simultaneous();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
